// File: rtl/ps2_kbd_pkg.sv
// Shared types, scan-code constants and the set-2 to ASCII translation
// for the PS/2 keyboard decoder.
package ps2_kbd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXTBRK,
    ST_PAUSE
  } kbd_state_t;

  // 'release' is a language keyword, so the break flag is named rel
  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       rel;
    logic [7:0] ascii;
    logic [3:0] mods;
  } kbd_event_t;

  localparam logic [7:0] SC_E0     = 8'hE0;
  localparam logic [7:0] SC_F0     = 8'hF0;
  localparam logic [7:0] SC_E1     = 8'hE1;
  localparam logic [7:0] SC_BAT    = 8'hAA;
  localparam logic [7:0] SC_ACK    = 8'hFA;
  localparam logic [7:0] SC_ECHO   = 8'hEE;
  localparam logic [7:0] SC_RESEND = 8'hFE;
  localparam logic [7:0] SC_ERR0   = 8'h00;
  localparam logic [7:0] SC_ERR1   = 8'hFF;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CTRL   = 8'h14;
  localparam logic [7:0] SC_ALT    = 8'h11;
  localparam logic [7:0] SC_CAPS   = 8'h58;
  localparam logic [7:0] SC_PAUSE  = 8'h77;
  localparam logic [2:0] PAUSE_SKIP = 3'd7;

  function automatic logic [7:0] scan_to_ascii(input logic [7:0] code,
                                               input logic shift,
                                               input logic caps,
                                               input logic ctrl);
    logic [4:0] letter;
    logic [7:0] res;
    letter = 5'd0;
    res    = 8'h00;
    case (code)
      8'h1C: letter = 5'd1;  8'h32: letter = 5'd2;  8'h21: letter = 5'd3;
      8'h23: letter = 5'd4;  8'h24: letter = 5'd5;  8'h2B: letter = 5'd6;
      8'h34: letter = 5'd7;  8'h33: letter = 5'd8;  8'h43: letter = 5'd9;
      8'h3B: letter = 5'd10; 8'h42: letter = 5'd11; 8'h4B: letter = 5'd12;
      8'h3A: letter = 5'd13; 8'h31: letter = 5'd14; 8'h44: letter = 5'd15;
      8'h4D: letter = 5'd16; 8'h15: letter = 5'd17; 8'h2D: letter = 5'd18;
      8'h1B: letter = 5'd19; 8'h2C: letter = 5'd20; 8'h3C: letter = 5'd21;
      8'h2A: letter = 5'd22; 8'h1D: letter = 5'd23; 8'h22: letter = 5'd24;
      8'h35: letter = 5'd25; 8'h1A: letter = 5'd26;
      default: letter = 5'd0;
    endcase
    if (letter != 5'd0) begin
      if (ctrl)               res = {3'b000, letter};
      else if (shift ^ caps)  res = 8'h40 | {3'b000, letter};
      else                    res = 8'h60 | {3'b000, letter};
    end else begin
      case (code)
        8'h16: res = shift ? 8'h21 : 8'h31;
        8'h1E: res = shift ? 8'h40 : 8'h32;
        8'h26: res = shift ? 8'h23 : 8'h33;
        8'h25: res = shift ? 8'h24 : 8'h34;
        8'h2E: res = shift ? 8'h25 : 8'h35;
        8'h36: res = shift ? 8'h5E : 8'h36;
        8'h3D: res = shift ? 8'h26 : 8'h37;
        8'h3E: res = shift ? 8'h2A : 8'h38;
        8'h46: res = shift ? 8'h28 : 8'h39;
        8'h45: res = shift ? 8'h29 : 8'h30;
        8'h29: res = 8'h20;
        8'h5A: res = 8'h0D;
        8'h66: res = 8'h08;
        8'h0D: res = 8'h09;
        8'h76: res = 8'h1B;
        default: res = 8'h00;
      endcase
    end
    return res;
  endfunction

endpackage

// File: rtl/ps2_kbd_decoder_fifo.sv
// Synchronous event FIFO; a push while full is accepted only when the
// head is popped in the same cycle, otherwise it is reported as dropped.
module kbd_event_fifo
  import ps2_kbd_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  kbd_event_t din,
  input  logic       ready,
  output logic       valid,
  output kbd_event_t dout,
  output logic       drop
);
  localparam int PW = $clog2(DEPTH);

  kbd_event_t    mem_q [DEPTH];
  kbd_event_t    mem_d [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic          full, pop, accept;

  assign full   = (cnt_q == (PW+1)'(DEPTH));
  assign valid  = (cnt_q != '0);
  assign pop    = valid && ready;
  assign accept = push && (!full || pop);
  assign drop   = push && full && !pop;
  assign dout   = mem_q[rd_q];

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (accept) begin
      mem_d[wr_q] = din;
      wr_d        = wr_q + PW'(1);
    end
    if (pop) rd_d = rd_q + PW'(1);
    if (accept && !pop)      cnt_d = cnt_q + (PW+1)'(1);
    else if (pop && !accept) cnt_d = cnt_q - (PW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ps2_kbd_decoder.sv
// PS/2 set-2 prefix parser with modifier/Caps tracking and ASCII translation;
// decoded key events are queued in kbd_event_fifo.
module ps2_kbd_decoder
  import ps2_kbd_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_done_tick,
  input  logic [7:0] rx_data,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic [7:0] ev_code,
  output logic       ev_ext,
  output logic       ev_release,
  output logic [7:0] ev_ascii,
  output logic [3:0] ev_mods,
  output logic [3:0] mods,
  output logic       overflow
);
  kbd_state_t state_q, state_d;
  logic [2:0] skip_q, skip_d;
  // held flags: {ralt, lalt, rctrl, lctrl, rshift, lshift}
  logic [5:0] held_q, held_d;
  logic       caps_q, caps_d, caps_held_q, caps_held_d;
  logic       overflow_q, overflow_d;
  logic       emit, em_ext, em_rel, drop;
  logic [7:0] em_code;
  logic [3:0] mods_d;
  kbd_event_t ev_in, ev_head;

  always_comb begin
    state_d = state_q;
    skip_d  = skip_q;
    emit    = 1'b0;
    em_code = rx_data;
    em_ext  = 1'b0;
    em_rel  = 1'b0;
    if (rx_done_tick) begin
      case (state_q)
        ST_IDLE: begin
          case (rx_data)
            SC_E0: state_d = ST_EXT;
            SC_F0: state_d = ST_BRK;
            SC_E1: begin
              state_d = ST_PAUSE;
              skip_d  = PAUSE_SKIP;
            end
            SC_BAT, SC_ACK, SC_ECHO, SC_RESEND, SC_ERR0, SC_ERR1: ;
            default: emit = 1'b1;
          endcase
        end
        ST_EXT: begin
          if (rx_data == SC_F0) state_d = ST_EXTBRK;
          else if (rx_data != SC_E0) begin
            state_d = ST_IDLE;
            emit    = (rx_data != SC_LSHIFT) && (rx_data != SC_RSHIFT);
            em_ext  = 1'b1;
          end
        end
        ST_BRK: begin
          state_d = ST_IDLE;
          emit    = 1'b1;
          em_rel  = 1'b1;
        end
        ST_EXTBRK: begin
          state_d = ST_IDLE;
          emit    = (rx_data != SC_LSHIFT) && (rx_data != SC_RSHIFT);
          em_ext  = 1'b1;
          em_rel  = 1'b1;
        end
        ST_PAUSE: begin
          skip_d = skip_q - 3'd1;
          if (skip_q <= 3'd1) begin
            state_d = ST_IDLE;
            emit    = (skip_q == 3'd1);
            em_code = SC_PAUSE;
            em_ext  = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Modifier state is updated by the event itself so its ASCII sees it
  always_comb begin
    held_d      = held_q;
    caps_d      = caps_q;
    caps_held_d = caps_held_q;
    if (emit) begin
      if (!em_ext) begin
        case (em_code)
          SC_LSHIFT: held_d[0] = !em_rel;
          SC_RSHIFT: held_d[1] = !em_rel;
          SC_CTRL:   held_d[2] = !em_rel;
          SC_ALT:    held_d[4] = !em_rel;
          SC_CAPS: begin
            if (!em_rel && !caps_held_q) caps_d = !caps_q;
            caps_held_d = !em_rel;
          end
          default: ;
        endcase
      end else begin
        case (em_code)
          SC_CTRL: held_d[3] = !em_rel;
          SC_ALT:  held_d[5] = !em_rel;
          default: ;
        endcase
      end
    end
    mods_d = {caps_d, held_d[5] | held_d[4], held_d[3] | held_d[2],
              held_d[1] | held_d[0]};
    ev_in.code  = em_code;
    ev_in.ext   = em_ext;
    ev_in.rel   = em_rel;
    ev_in.ascii = (em_rel || em_ext) ? 8'h00
                : scan_to_ascii(em_code, mods_d[0], mods_d[3], mods_d[1]);
    ev_in.mods  = mods_d;
    overflow_d  = overflow_q | drop;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      skip_q      <= 3'd0;
      held_q      <= 6'd0;
      caps_q      <= 1'b0;
      caps_held_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      skip_q      <= skip_d;
      held_q      <= held_d;
      caps_q      <= caps_d;
      caps_held_q <= caps_held_d;
      overflow_q  <= overflow_d;
    end
  end

  kbd_event_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (emit),
    .din   (ev_in),
    .ready (ev_ready),
    .valid (ev_valid),
    .dout  (ev_head),
    .drop  (drop)
  );

  assign ev_code    = ev_head.code;
  assign ev_ext     = ev_head.ext;
  assign ev_release = ev_head.rel;
  assign ev_ascii   = ev_head.ascii;
  assign ev_mods    = ev_head.mods;
  assign mods       = {caps_q, held_q[5] | held_q[4], held_q[3] | held_q[2],
                       held_q[1] | held_q[0]};
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_ps2_kbd_decoder.sv
// Directed bench for ps2_kbd_decoder: prefixes, modifiers, Caps, Pause,
// FIFO overflow/pop-while-full and reset mid-prefix.
module tb_ps2_kbd_decoder;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_done_tick = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       ev_valid, ev_ready = 1'b0;
  logic [7:0] ev_code, ev_ascii;
  logic       ev_ext, ev_release, overflow;
  logic [3:0] ev_mods, mods;
  int checks = 0;
  int errors = 0;

  ps2_kbd_decoder #(.FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .rx_done_tick(rx_done_tick), .rx_data(rx_data),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_code(ev_code),
    .ev_ext(ev_ext), .ev_release(ev_release), .ev_ascii(ev_ascii),
    .ev_mods(ev_mods), .mods(mods), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_done_tick = 1'b1;
    rx_data      = b;
    @(negedge clk);
    rx_done_tick = 1'b0;
  endtask

  // checks the head {valid, code, ext, release, ascii, mods} then pops it
  task automatic pop_ev(input string tag, input logic [7:0] code, input logic ext,
                        input logic rel, input logic [7:0] ascii, input logic [3:0] md);
    chk(tag, {ev_valid, ev_code, ev_ext, ev_release, ev_ascii, ev_mods},
        {1'b1, code, ext, rel, ascii, md});
    ev_ready = 1'b1;
    @(negedge clk);
    ev_ready = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_state", {ev_valid, mods, overflow, ev_code, ev_ascii}, 32'h0);

    // make/break of 'a' with the consumer always ready
    ev_ready = 1'b1;
    send(8'h1C);
    chk("a_make", {ev_valid, ev_code, ev_release, ev_ascii}, {1'b1, 8'h1C, 1'b0, 8'h61});
    send(8'hF0);
    chk("f0_no_event", ev_valid, 1'b0);
    send(8'h1C);
    chk("a_break", {ev_valid, ev_code, ev_release, ev_ascii}, {1'b1, 8'h1C, 1'b1, 8'h00});
    @(negedge clk);
    ev_ready = 1'b0;
    chk("drained", ev_valid, 1'b0);

    // shift, then caps lock
    send(8'h12);        pop_ev("lshift_make", 8'h12, 0, 0, 8'h00, 4'b0001);
    send(8'h1C);        pop_ev("A_shift",     8'h1C, 0, 0, 8'h41, 4'b0001);
    send(8'hF0); send(8'h12); pop_ev("lshift_brk", 8'h12, 0, 1, 8'h00, 4'b0000);
    send(8'h58);        pop_ev("caps_make",   8'h58, 0, 0, 8'h00, 4'b1000);
    send(8'hF0); send(8'h58); pop_ev("caps_brk", 8'h58, 0, 1, 8'h00, 4'b1000);
    send(8'h1C);        pop_ev("A_caps",      8'h1C, 0, 0, 8'h41, 4'b1000);
    chk("mods_caps", mods, 4'b1000);
    // typematic repeat of caps must toggle only once
    send(8'h58);        pop_ev("caps_off",    8'h58, 0, 0, 8'h00, 4'b0000);
    send(8'h58);        pop_ev("caps_repeat", 8'h58, 0, 0, 8'h00, 4'b0000);
    send(8'hF0); send(8'h58); pop_ev("caps_brk2", 8'h58, 0, 1, 8'h00, 4'b0000);

    // right ctrl and ctrl-c, fake shift is dropped
    send(8'hE0); send(8'h14); pop_ev("rctrl_make", 8'h14, 1, 0, 8'h00, 4'b0010);
    chk("mods_ctrl", mods, 4'b0010);
    send(8'h21);        pop_ev("ctrl_c",      8'h21, 0, 0, 8'h03, 4'b0010);
    send(8'hE0); send(8'hF0); send(8'h14); pop_ev("rctrl_brk", 8'h14, 1, 1, 8'h00, 4'b0000);
    send(8'hE0); send(8'h12);
    send(8'hAA);
    chk("fake_shift_bat_dropped", {ev_valid, mods}, 5'h0);

    // back-to-back ticks, digits unshifted then shifted
    @(negedge clk);
    rx_done_tick = 1'b1; rx_data = 8'h16;
    @(negedge clk);
    rx_data = 8'h1E;
    @(negedge clk);
    rx_done_tick = 1'b0;
    pop_ev("digit1", 8'h16, 0, 0, 8'h31, 4'b0000);
    pop_ev("digit2", 8'h1E, 0, 0, 8'h32, 4'b0000);
    send(8'h59);        pop_ev("rshift_make", 8'h59, 0, 0, 8'h00, 4'b0001);
    send(8'h36);        pop_ev("caret",       8'h36, 0, 0, 8'h5E, 4'b0001);
    send(8'hF0); send(8'h59); pop_ev("rshift_brk", 8'h59, 0, 1, 8'h00, 4'b0000);

    // pause: exactly one event
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0);
    chk("pause_inner_quiet", ev_valid, 1'b0);
    send(8'h77);        pop_ev("pause", 8'h77, 1, 0, 8'h00, 4'b0000);
    chk("pause_single", ev_valid, 1'b0);

    // overflow, then pop and push in the same cycle while full
    send(8'h1C); send(8'h32); send(8'h21); send(8'h23);
    chk("no_overflow_at_full", overflow, 1'b0);
    send(8'h24);
    chk("overflow_set", overflow, 1'b1);
    chk("head_a", {ev_valid, ev_code, ev_ascii}, {1'b1, 8'h1C, 8'h61});
    @(negedge clk);
    ev_ready = 1'b1; rx_done_tick = 1'b1; rx_data = 8'h2B;
    @(negedge clk);
    ev_ready = 1'b0; rx_done_tick = 1'b0;
    pop_ev("fifo_b", 8'h32, 0, 0, 8'h62, 4'b0000);
    pop_ev("fifo_c", 8'h21, 0, 0, 8'h63, 4'b0000);
    pop_ev("fifo_d", 8'h23, 0, 0, 8'h64, 4'b0000);
    pop_ev("fifo_f", 8'h2B, 0, 0, 8'h66, 4'b0000);
    chk("fifo_empty_overflow_sticky", {ev_valid, overflow}, 2'b01);

    // reset in the middle of an E0 prefix
    send(8'h12);
    send(8'hE0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("post_rst", {ev_valid, overflow, mods, ev_code, ev_ascii}, 32'h0);
    send(8'h1C);        pop_ev("after_rst", 8'h1C, 0, 0, 8'h61, 4'b0000);
    chk("after_rst_single", ev_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule
